seq_run_ctrl: RTL and testbench
===============================

Name: seq_run_ctrl

Overview:
- Run/step controller for the team's 3-bit feedback sequence generator (Q1/Q2/Q3 shift-and-feedback datapath plus carry flag).
- Embeds the generator register and gates its advance with an FSM:
  - free-run
  - bounded run of N steps
  - pause/resume
  - single-step
  - seed load
- Optionally measures the sequence period from the run's starting state.
- Sits between the board-level push-button/switch logic and the display outputs.

Parameters:
- CNT_W, 8, width of the run-length counter, the period counter and the `len`/`period` ports.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled command: begin run (IDLE) / resume (PAUSE)
- stop  in  1  level-sampled command: pause (RUN) / abort (PAUSE)
- step  in  1  level-sampled command: advance exactly once (IDLE only)
- seed_load  in  1  load `seed` into the generator (IDLE only)
- seed  in  3  seed value {q1,q2,q3}
- len  in  CNT_W  run length in advances; 0 = free-run until stop
- q  out  3  generator state {Q1,Q2,Q3}
- c  out  1  registered carry flag
- busy  out  1  high in RUN or PAUSE
- done  out  1  one-cycle pulse when a bounded run completes
- period  out  CNT_W  measured period in advances
- period_valid  out  1  `period` holds a valid measurement

Behaviour:
- Reset (async, reset_n=0):
  - q=000, c=0, FSM=IDLE
  - busy=0, done=0, period=0, period_valid=0
  - remaining counter=0, period counter=0
- Advance (one clock edge), applied simultaneously to the pre-edge state:
  - Q1<=~Q3, Q2<=Q1, Q3<=Q1&Q2
  - c<=Q1|~Q3
  - From 000 the sequence is 100,110,111,011,000 (period 5).
- Command priority when several are high in one cycle: stop > start > step > seed_load.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start: load remaining<=len; go to RUN. No advance on this edge.
  - step: one advance; stay IDLE.
  - seed_load: q<=seed; c unchanged.
  - stop: ignored.
- RUN:
  - stop (highest priority): go to PAUSE, no advance.
  - Otherwise advance every edge.
  - If len was nonzero, decrement remaining on each advance. The edge that advances with remaining==1 also moves the FSM to DONE.
  - start, step and seed_load are ignored.
- PAUSE:
  - Generator held.
  - start: return to RUN with `remaining` retained.
  - stop: abort to IDLE; no done pulse; q keeps its current value.
  - step and seed_load are ignored.
- DONE: done=1 for exactly this one cycle; unconditionally go to IDLE next edge. All commands are ignored.
- Latency: start sampled at edge T gives the first advance at edge T+1. A len=N run advances at edges T+1..T+N and done is high during cycle T+N.
- busy = (FSM==RUN)|(FSM==PAUSE), registered with the FSM.
- Free-run (len=0): never reaches DONE; exits only via stop→PAUSE→stop.
- Reset mid-run: immediate return to the reset values above. A pending period measurement is discarded.

Optional Feature:
- Macro: SEQ_PERIOD_DET_EN.
- Defined:
  - On start from IDLE: ref<=q, pcnt<=0, period_valid<=0, period<=0.
  - On each RUN advance: pcnt<=pcnt+1, saturating at all-ones.
  - If the post-advance state equals ref and period_valid==0: period<=pcnt+1, period_valid<=1. Later matches are ignored.
  - Values persist through PAUSE, DONE and IDLE until the next start from IDLE or reset.
  - Step advances in IDLE do not count.
- Not defined: period and period_valid are tied to 0; ref and pcnt are not implemented.

Test Plan:
- Reset 0 with start held high, release after 3 cycles → q=000, c=0, busy=0, done=0 throughout; FSM leaves IDLE only on the first edge after release.
- seed_load seed=000, then start with len=7 → q after edges T+1..T+7 is 100,110,111,011,000,100,110; done=1 only in cycle T+7; busy=0 from T+8; with SEQ_PERIOD_DET_EN, period=5 and period_valid=1.
- len=0 start, stop after 3 advances, hold 4 cycles, start again → q frozen at 111 during PAUSE, then resumes 011,000; busy stays 1; stop twice from PAUSE → IDLE, done never asserted.
- Seed 101, start len=10 (SEQ_PERIOD_DET_EN) → sequence 010,100,110,111,011,000,100,…; 101 never recurs; period_valid=0 after done.
- In IDLE, assert step and seed_load (seed=111) together → one advance from the current q, seed ignored. Next cycle seed_load alone → q=111. During RUN, step and seed_load have no effect.
- Start len=4, drive reset_n low at the edge after the 2nd advance → q=000, busy=0, period_valid=0 immediately; no done pulse after reset release.

Source files
------------

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: run/step controller for the 3-bit feedback sequence generator.
// Define SEQ_PERIOD_DET_EN to build the period measurement from the run's starting state.
module seq_run_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             seed_load,
  input  logic [2:0]       seed,
  input  logic [CNT_W-1:0] len,
  output logic [2:0]       q,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic adv, load, go;
  logic [2:0] q_adv;
  assign q_adv = {~q[0], q[2], q[2] & q[1]};
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    adv      = 1'b0;
    load     = 1'b0;
    go       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          rem_nx   = len;
          go       = 1'b1;
        end else if (step) adv = 1'b1;
        else if (seed_load) load = 1'b1;
      end
      RUN: begin
        if (stop) state_nx = PAUSE;
        else begin
          adv = 1'b1;
          // rem==0 at this point only for a free run; bounded runs end at 1
          if (rem != '0) begin
            rem_nx = rem - 1'b1;
            if (rem == CNT_W'(1)) state_nx = DONE;
          end
        end
      end
      PAUSE:   state_nx = stop ? IDLE : (start ? RUN : PAUSE);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rem   <= '0;
      q     <= 3'b000;
      c     <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      if (adv) begin
        q <= q_adv;
        c <= q[2] | ~q[0];
      end else if (load) q <= seed;
    end
  end
  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);
`ifdef SEQ_PERIOD_DET_EN
  logic [2:0] ref_q;
  logic [CNT_W-1:0] pcnt, pcnt_inc;
  assign pcnt_inc = &pcnt ? pcnt : pcnt + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q        <= 3'b000;
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (go) begin
      ref_q        <= q;
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (adv && state == RUN) begin
      pcnt <= pcnt_inc;
      // only the first return to the starting state is the period
      if (q_adv == ref_q && !period_valid) begin
        period       <= pcnt_inc;
        period_valid <= 1'b1;
      end
    end
  end
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_seq_run_ctrl.sv
// tb_seq_run_ctrl: directed-vector bench for seq_run_ctrl with hand-computed expectations.
module tb_seq_run_ctrl;
  localparam int CNT_W = 8;
`ifdef SEQ_PERIOD_DET_EN
  localparam logic [CNT_W-1:0] EXP_P = 5;
  localparam logic EXP_V = 1'b1;
`else
  localparam logic [CNT_W-1:0] EXP_P = 0;
  localparam logic EXP_V = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, step = 1'b0, seed_load = 1'b0;
  logic [2:0] seed = 3'b000;
  logic [CNT_W-1:0] len = '0;
  logic [2:0] q;
  logic c, busy, done, period_valid;
  logic [CNT_W-1:0] period;
  int n_chk = 0, n_fail = 0;
  seq_run_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .step(step),
    .seed_load(seed_load), .seed(seed), .len(len), .q(q), .c(c), .busy(busy),
    .done(done), .period(period), .period_valid(period_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  logic [2:0] s7[7]  = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b000, 3'b100, 3'b110};
  logic [2:0] s10[10] = '{3'b010, 3'b100, 3'b110, 3'b111, 3'b011, 3'b000, 3'b100, 3'b110, 3'b111, 3'b011};
  initial begin
    // reset held with start high
    reset_n = 1'b0;
    start = 1'b1;
    #1;
    chk("rst_q0", q, 3'b000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_q", q, 3'b000);
      chk("rst_c", c, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pv", period_valid, 1'b0);
    end
    reset_n = 1'b1;
    cyc();
    chk("rel_busy", busy, 1'b1);
    chk("rel_q", q, 3'b000);
    start = 1'b0;
    stop = 1'b1;
    cyc();
    chk("rel_pause_q", q, 3'b000);
    chk("rel_pause_busy", busy, 1'b1);
    cyc();
    chk("rel_abort_busy", busy, 1'b0);
    stop = 1'b0;
    // bounded run of 7 from 000
    seed = 3'b000;
    seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    chk("t2_seed", q, 3'b000);
    len = 7;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t2_start_q", q, 3'b000);
    chk("t2_start_busy", busy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("t2_q%0d", i + 1), q, s7[i]);
      chk($sformatf("t2_done%0d", i + 1), done, i == 6);
      if (i == 0) chk("t2_c1", c, 1'b1);
      if (i == 4) chk("t2_c5", c, 1'b0);
    end
    cyc();
    chk("t2_busy_after", busy, 1'b0);
    chk("t2_done_after", done, 1'b0);
    chk("t2_q_hold", q, 3'b110);
    chk("t2_period", period, EXP_P);
    chk("t2_pv", period_valid, EXP_V);
    // free run, pause, resume, abort
    seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    len = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_run_done", done, 1'b0);
    end
    chk("t3_q3", q, 3'b111);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_pause_q", q, 3'b111);
      chk("t3_pause_busy", busy, 1'b1);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t3_resume_q", q, 3'b111);
    cyc();
    chk("t3_r1", q, 3'b011);
    chk("t3_r1_busy", busy, 1'b1);
    cyc();
    chk("t3_r2", q, 3'b000);
    stop = 1'b1;
    cyc();
    chk("t3_p_busy", busy, 1'b1);
    chk("t3_p_done", done, 1'b0);
    cyc();
    stop = 1'b0;
    chk("t3_abort_busy", busy, 1'b0);
    chk("t3_abort_done", done, 1'b0);
    chk("t3_abort_q", q, 3'b000);
    cyc();
    chk("t3_idle_done", done, 1'b0);
    // seed 101, len 10: starting state never recurs
    seed = 3'b101;
    seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    chk("t4_seed", q, 3'b101);
    len = 10;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("t4_q%0d", i + 1), q, s10[i]);
      chk($sformatf("t4_done%0d", i + 1), done, i == 9);
    end
    cyc();
    chk("t4_pv", period_valid, 1'b0);
    chk("t4_period", period, 0);
    chk("t4_busy", busy, 1'b0);
    // step beats seed_load in IDLE; both ignored in RUN
    step = 1'b1;
    seed_load = 1'b1;
    seed = 3'b111;
    cyc();
    step = 1'b0;
    chk("t5_step", q, 3'b000);
    cyc();
    chk("t5_seed", q, 3'b111);
    step = 1'b1;
    seed = 3'b010;
    len = 3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t5_start_q", q, 3'b111);
    cyc();
    chk("t5_r1", q, 3'b011);
    cyc();
    chk("t5_r2", q, 3'b000);
    step = 1'b0;
    seed_load = 1'b0;
    cyc();
    chk("t5_r3", q, 3'b100);
    chk("t5_done", done, 1'b1);
    cyc();
    chk("t5_idle_q", q, 3'b100);
    chk("t5_idle_done", done, 1'b0);
    // reset in the middle of a bounded run
    seed = 3'b000;
    seed_load = 1'b1;
    cyc();
    seed_load = 1'b0;
    len = 4;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("t6_a1", q, 3'b100);
    cyc();
    chk("t6_a2", q, 3'b110);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_q", q, 3'b000);
    chk("t6_rst_c", c, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pv", period_valid, 1'b0);
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t6_post_done", done, 1'b0);
      chk("t6_post_q", q, 3'b000);
      chk("t6_post_busy", busy, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
